// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join collector.
//   join_mode_e : join condition selected at session start
//   fjc_state_e : collector FSM state
//   id_w()      : width of a worker id for a given worker count
package fork_join_pkg;

    typedef enum logic [1:0] {
        JOIN_ALL  = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2
    } join_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fjc_state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fjc_order_fifo.sv
// Completion-order FIFO of {id, data, time}, show-ahead.
// Up to N pushes per cycle (lowest index lands first), one pop per cycle.
// Storage is a shift register: the head always sits in slot 0.
//   push      : per-worker push strobe
//   push_data : per-worker result
//   push_time : completion time shared by every push of this cycle
//   pop       : consume head (ignored when empty)
//   valid     : FIFO non-empty, head_* meaningful
//   head_*    : head entry fields
module fjc_order_fifo #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int TIME_W = 16,
    parameter int IDW    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 push,
    input  logic [N-1:0][DATA_W-1:0]     push_data,
    input  logic [TIME_W-1:0]            push_time,
    input  logic                         pop,
    output logic                         valid,
    output logic [IDW-1:0]               head_id,
    output logic [DATA_W-1:0]            head_data,
    output logic [TIME_W-1:0]            head_time
);

    localparam int CW = $clog2(N + 1);

    typedef struct packed {
        logic [IDW-1:0]    id;
        logic [DATA_W-1:0] data;
        logic [TIME_W-1:0] tm;
    } ent_t;

    ent_t [N-1:0]  mem;
    ent_t [N-1:0]  mem_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_pop;
    int            slot;

    always_comb begin
        do_pop  = pop && (count != '0);
        mem_nxt = mem;
        // shift down on pop; slots past the live entries are don't-care
        for (int k = 0; k < N; k++)
            if (do_pop && (k < N - 1))
                mem_nxt[k] = mem[k + 1];
        // append this cycle's completions behind the surviving entries
        slot = int'(count) - (do_pop ? 1 : 0);
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                if (slot < N)
                    mem_nxt[slot] = '{id: IDW'(i), data: push_data[i], tm: push_time};
                slot = slot + 1;
            end
        end
        count_nxt = CW'(slot);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            count <= '0;
        end else begin
            mem   <= mem_nxt;
            count <= count_nxt;
        end
    end

    assign valid     = (count != '0);
    assign head_id   = mem[0].id;
    assign head_data = mem[0].data;
    assign head_time = mem[0].tm;

endmodule

// File: rtl/fork_join_collector.sv
// Join side of a fork/dispatch unit. Tracks the workers of one session,
// fires join_fire per the latched join mode and streams results out in
// completion order tagged with worker id and session-relative time.
//   start/start_mode/start_mask : open a session (needs idle + empty FIFO)
//   start_err                   : pulse, start rejected
//   done_valid/done_data        : per-worker completion pulse and result
//   busy                        : masked workers still outstanding
//   join_fire                   : one pulse per session
//   first_id                    : first completer of the session
//   res_*                       : show-ahead result stream, pop on valid&ready
//   err_unexpected              : pulse, completion from a non-pending worker
module fork_join_collector
    import fork_join_pkg::*;
#(
    parameter int N_WORKERS = 4,
    parameter int DATA_W    = 32,
    parameter int TIME_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    start_mode,
    input  logic [N_WORKERS-1:0]          start_mask,
    output logic                          start_err,
    input  logic [N_WORKERS-1:0]          done_valid,
    input  logic [N_WORKERS*DATA_W-1:0]   done_data,
    output logic                          busy,
    output logic                          join_fire,
    output logic [id_w(N_WORKERS)-1:0]    first_id,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [id_w(N_WORKERS)-1:0]    res_id,
    output logic [DATA_W-1:0]             res_data,
    output logic [TIME_W-1:0]             res_time,
    output logic                          err_unexpected
);

    localparam int IDW = id_w(N_WORKERS);

    fjc_state_e                          state;
    join_mode_e                          mode;
    join_mode_e                          start_jm;
    logic [N_WORKERS-1:0]                pending;
    logic [N_WORKERS-1:0]                pending_nxt;
    logic [N_WORKERS-1:0]                hit;
    logic [N_WORKERS-1:0]                unexp;
    logic                                first_seen;
    logic [TIME_W-1:0]                   cnt;
    logic [TIME_W-1:0]                   t_now;
    logic                                accept;
    logic [N_WORKERS-1:0][DATA_W-1:0]    wdata;

    function automatic logic [IDW-1:0] lowest(input logic [N_WORKERS-1:0] v);
        lowest = '0;
        for (int i = N_WORKERS - 1; i >= 0; i--)
            if (v[i]) lowest = IDW'(i);
    endfunction

    // pending is all-zero outside a session, so every pulse in IDLE is unexpected
    assign hit         = done_valid & pending;
    assign unexp       = done_valid & ~pending;
    assign pending_nxt = pending & ~hit;
    // cnt lags the reported time by one: first WAIT cycle reports 1
    assign t_now       = (&cnt) ? cnt : cnt + 1'b1;
    assign accept      = start && (state == ST_IDLE) && !res_valid;
    assign start_jm    = (start_mode == 2'd3) ? JOIN_ALL : join_mode_e'(start_mode);
    assign wdata       = done_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            mode           <= JOIN_ALL;
            pending        <= '0;
            first_seen     <= 1'b0;
            first_id       <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            join_fire      <= 1'b0;
            start_err      <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            join_fire      <= 1'b0;
            start_err      <= start && !accept;
            err_unexpected <= |unexp;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pending    <= start_mask;
                        mode       <= start_jm;
                        cnt        <= '0;
                        first_seen <= 1'b0;
                        first_id   <= '0;
                        if (start_mask != '0) begin
                            state <= ST_WAIT;
                            busy  <= 1'b1;
                            if (start_jm == JOIN_NONE) join_fire <= 1'b1;
                        end else begin
                            // empty session joins immediately in every mode
                            join_fire <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt     <= t_now;
                    pending <= pending_nxt;
                    if ((hit != '0) && !first_seen) begin
                        first_seen <= 1'b1;
                        first_id   <= lowest(hit);
                        if (mode == JOIN_ANY) join_fire <= 1'b1;
                    end
                    if (pending_nxt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (mode == JOIN_ALL) join_fire <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fjc_order_fifo #(
        .N      (N_WORKERS),
        .DATA_W (DATA_W),
        .TIME_W (TIME_W),
        .IDW    (IDW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (hit & {N_WORKERS{state == ST_WAIT}}),
        .push_data (wdata),
        .push_time (t_now),
        .pop       (res_ready),
        .valid     (res_valid),
        .head_id   (res_id),
        .head_data (res_data),
        .head_time (res_time)
    );

endmodule

// File: tb/tb_fork_join_collector.sv
// Randomized and directed bench for fork_join_collector with a queue-based
// reference model. Cycle 0 of a session is the cycle start is driven.
module tb_fork_join_collector;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int TW   = 6;
    localparam int TMAX = (1 << TW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [1:0]      start_mode;
    logic [N-1:0]    start_mask;
    logic            start_err;
    logic [N-1:0]    done_valid;
    logic [N*DW-1:0] done_data;
    logic            busy;
    logic            join_fire;
    logic [1:0]      first_id;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_id;
    logic [DW-1:0]   res_data;
    logic [TW-1:0]   res_time;
    logic            err_unexpected;

    fork_join_collector #(.N_WORKERS(N), .DATA_W(DW), .TIME_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_mode(start_mode),
        .start_mask(start_mask), .start_err(start_err), .done_valid(done_valid),
        .done_data(done_data), .busy(busy), .join_fire(join_fire),
        .first_id(first_id), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data), .res_time(res_time),
        .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          tm;
    } res_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    res_t        q[$];
    int          cyc[N];
    logic [31:0] dat[N];
    int          rogue_id;
    int          rogue_cyc;
    int          restart_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 0; start_mode = 0; start_mask = 0;
        done_valid = 0; done_data = 0; res_ready = 0;
    endtask

    task automatic check_head();
        chk("res_valid", res_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("res_id",   res_id,   q[0].id);
            chk("res_data", res_data, q[0].data);
            chk("res_time", res_time, q[0].tm);
        end
    endtask

    task automatic clear_extras();
        rogue_id = -1; rogue_cyc = -1; restart_cyc = -1;
    endtask

    // Expected behaviour derived from the completion schedule:
    // busy over cycles 1..last, join one cycle after its trigger,
    // results in (cycle, id) order with time = completion cycle (saturating).
    task automatic run_session(input int mode, input logic [N-1:0] mask, input int rdy_pct);
        int maxc = 0;
        int minc = 1 << 30;
        int fid  = 0;
        int jf;
        int k    = 0;
        logic [N-1:0]    dv;
        logic [N*DW-1:0] dd;
        for (int i = 0; i < N; i++)
            if (mask[i]) begin
                if (cyc[i] > maxc) maxc = cyc[i];
                if (cyc[i] < minc) begin minc = cyc[i]; fid = i; end
            end
        if (mask == 0 || mode == 2) jf = 1;
        else if (mode == 1)         jf = minc + 1;
        else                        jf = maxc + 1;
        while ((k <= maxc + 1 || (rdy_pct > 0 && q.size() > 0)) && k < 400) begin
            start      = (k == 0) || (k == restart_cyc);
            start_mode = mode[1:0];
            start_mask = mask;
            dv = '0; dd = '0;
            for (int i = 0; i < N; i++)
                if ((mask[i] && cyc[i] == k && k >= 1) || (rogue_id == i && rogue_cyc == k)) begin
                    dv[i] = 1'b1;
                    dd[i*DW +: DW] = dat[i];
                end
            done_valid = dv;
            done_data  = dd;
            res_ready  = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            chk("busy", busy, (mask != 0) && k >= 1 && k <= maxc);
            chk("join_fire", join_fire, k == jf);
            chk("err_unexpected", err_unexpected, rogue_cyc >= 0 && k == rogue_cyc + 1);
            chk("start_err", start_err, restart_cyc >= 1 && k == restart_cyc + 1);
            check_head();
            if (mask != 0 && k == maxc + 1) chk("first_id", first_id, fid);
            if (q.size() > 0 && res_ready) void'(q.pop_front());
            for (int i = 0; i < N; i++)
                if (mask[i] && cyc[i] == k && k >= 1)
                    q.push_back('{id: i, data: dat[i], tm: (k > TMAX) ? TMAX : k});
            @(posedge clk); #1;
            k++;
        end
        if (rdy_pct > 0) chk("drain", q.size(), 0);
        idle_inputs();
        clear_extras();
    endtask

    task automatic set_plan(input int c0, input int c1, input int c2, input int c3);
        cyc[0] = c0; cyc[1] = c1; cyc[2] = c2; cyc[3] = c3;
    endtask

    initial begin
        int quiet;
        logic [N-1:0] m;
        idle_inputs();
        clear_extras();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_join", join_fire, 0);
        chk("rst_rvalid", res_valid, 0);
        chk("rst_res", {res_id, res_time, res_data[23:0]}, 0);
        chk("rst_first", first_id, 0);
        chk("rst_errs", {start_err, err_unexpected}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // directed schedule: 30/20/40/10, data 15/130/60/55
        set_plan(30, 20, 40, 10);
        dat[0] = 15; dat[1] = 130; dat[2] = 60; dat[3] = 55;
        run_session(1, 4'b1111, 100);
        run_session(0, 4'b1111, 100);
        run_session(2, 4'b1111, 60);

        // simultaneous completions
        set_plan(9, 5, 5, 9);
        dat[1] = 32'h1111_0001; dat[2] = 32'h2222_0002;
        run_session(0, 4'b0110, 100);

        // hold results, rejected start, drain, accepted start
        set_plan(30, 20, 40, 10);
        run_session(0, 4'b1111, 0);
        start = 1; start_mode = 0; start_mask = 4'b1111;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("hold_start_err", start_err, 1);
        chk("hold_busy", busy, 0);
        check_head();
        @(posedge clk); #1;
        res_ready = 1;
        for (int g = 0; g < 20 && q.size() > 0; g++) begin
            @(negedge clk);
            check_head();
            void'(q.pop_front());
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_head();
        @(posedge clk); #1;
        idle_inputs();
        set_plan(3, 7, 7, 2);
        dat[0] = 32'hdead; dat[1] = 32'hbeef; dat[2] = 32'hcafe; dat[3] = 32'hf00d;
        run_session(1, 4'b1111, 100);

        // unexpected worker 0 outside the mask
        set_plan(0, 4, 6, 8);
        rogue_id = 0; rogue_cyc = 3;
        run_session(0, 4'b1110, 100);

        // empty mask joins next cycle, never busy
        run_session(1, 4'b0000, 100);

        // time saturation
        set_plan(70, 0, 0, 0);
        dat[0] = 32'h5a5a;
        run_session(3, 4'b0001, 100);

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            int mode;
            int maxc;
            m    = 4'($urandom_range(15));
            mode = $urandom_range(3);
            maxc = 0;
            for (int i = 0; i < N; i++) begin
                cyc[i] = 1 + $urandom_range(11);
                dat[i] = $urandom;
                if (m[i] && cyc[i] > maxc) maxc = cyc[i];
            end
            if (m != 4'b1111 && $urandom_range(1)) begin
                for (int i = 0; i < N; i++) if (!m[i]) rogue_id = i;
                rogue_cyc = $urandom_range(maxc);
            end
            if (m != 0 && $urandom_range(1)) restart_cyc = 1 + $urandom_range(maxc - 1);
            run_session(mode, m, 30 + 35 * $urandom_range(2));
        end

        // reset mid JOIN_ALL session
        start = 1; start_mode = 0; start_mask = 4'b1111;
        dat[3] = 32'h77;
        for (int k = 0; k < 25; k++) begin
            done_valid = (k == 10) ? 4'b1000 : 4'b0000;
            done_data  = '0;
            done_data[3*DW +: DW] = dat[3];
            @(posedge clk); #1;
            start = 0;
        end
        chk("pre_rst_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rvalid", res_valid, 0);
        chk("arst_res", {res_id, res_time, res_data[23:0]}, 0);
        chk("arst_first", first_id, 0);
        chk("arst_join", join_fire, 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        quiet = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (join_fire || busy || res_valid) quiet++;
        end
        chk("post_rst_quiet", quiet, 0);
        q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
